// File: rtl/dcache_pkg.sv
// Shared types and helpers for the L1 data cache: access sizes, FSM states,
// store strobe/lane generation and load alignment.
package dcache_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    BYTE      = 2'd0,
    HALF_WORD = 2'd1,
    WORD      = 2'd2
  } mem_access_t;

  typedef enum logic [2:0] {
    StIdle,
    StRefillReq,
    StRefillWait,
    StWriteReq,
    StWriteWait,
    StAck
  } dcache_state_t;

  function automatic logic [3:0] get_wr_strobe(mem_access_t access, logic [1:0] offset);
    logic [3:0] strb;
    case (access)
      BYTE:      strb = 4'b0001 << offset;
      HALF_WORD: strb = 4'b0011 << {offset[1], 1'b0};
      WORD:      strb = 4'hF;
      default:   strb = 4'h0;
    endcase
    return strb;
  endfunction

  // Replicate right-aligned store data into every lane it could occupy.
  function automatic logic [XLEN-1:0] get_wr_lanes(mem_access_t access, logic [XLEN-1:0] data);
    logic [XLEN-1:0] lanes;
    case (access)
      BYTE:      lanes = {4{data[7:0]}};
      HALF_WORD: lanes = {2{data[15:0]}};
      default:   lanes = data;
    endcase
    return lanes;
  endfunction

  function automatic logic [1:0] get_load_offset(mem_access_t access, logic [1:0] offset);
    logic [1:0] eff;
    case (access)
      BYTE:      eff = offset;
      HALF_WORD: eff = {offset[1], 1'b0};
      default:   eff = 2'b00;
    endcase
    return eff;
  endfunction

  function automatic logic [XLEN-1:0] align_load(logic [XLEN-1:0] word, logic [1:0] offset);
    return word >> {offset, 3'b000};
  endfunction

endpackage

// File: rtl/dcache_if.sv
// Backing-memory bus between the data cache (master) and memory (slave).
interface dcache_if;
  import dcache_pkg::*;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic            mem_req_we;
  logic [XLEN-1:0] mem_req_addr;
  logic [XLEN-1:0] mem_req_wdata;
  logic [3:0]      mem_req_wstrb;
  logic            mem_resp_valid;
  logic [XLEN-1:0] mem_resp_data;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );

endinterface

// File: rtl/dcache_array.sv
// Valid/tag/data flop storage for the cache with asynchronous read, word fill,
// byte-strobed merge and a synchronous clear of all valid bits on reset.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned WordW = 2,
  parameter int unsigned IdxW  = 6,
  parameter int unsigned TagW  = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IdxW-1:0]  index_i,
  input  logic [WordW-1:0] rd_word_i,
  output logic             valid_o,
  output logic [TagW-1:0]  tag_o,
  output logic [XLEN-1:0]  rdata_o,
  input  logic             fill_en_i,
  input  logic [WordW-1:0] fill_word_i,
  input  logic [XLEN-1:0]  fill_data_i,
  input  logic             tag_set_en_i,
  input  logic [TagW-1:0]  tag_i,
  input  logic             merge_en_i,
  input  logic [3:0]       merge_strb_i,
  input  logic [XLEN-1:0]  merge_wdata_i
);

  localparam int unsigned Sets    = 1 << IdxW;
  localparam int unsigned Entries = Sets << WordW;

  logic [Sets-1:0]        valid_q, valid_d;
  logic [TagW-1:0]        tag_q  [Sets];
  logic [XLEN-1:0]        data_q [Entries];
  logic [IdxW+WordW-1:0]  rd_ptr, fill_ptr;
  logic [XLEN-1:0]        merge_word;

  assign rd_ptr   = {index_i, rd_word_i};
  assign fill_ptr = {index_i, fill_word_i};
  assign valid_o  = valid_q[index_i];
  assign tag_o    = tag_q[index_i];
  assign rdata_o  = data_q[rd_ptr];

  always_comb begin
    valid_d = valid_q;
    if (tag_set_en_i) valid_d[index_i] = 1'b1;
    merge_word = data_q[rd_ptr];
    for (int b = 0; b < 4; b++) begin
      if (merge_strb_i[b]) merge_word[8*b +: 8] = merge_wdata_i[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Tags and data need no reset: nothing is trusted without its valid bit.
  always_ff @(posedge clk) begin
    if (fill_en_i)        data_q[fill_ptr] <= fill_data_i;
    else if (merge_en_i)  data_q[rd_ptr]   <= merge_word;
    if (tag_set_en_i)     tag_q[index_i]   <= tag_i;
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache: FSM, refill
// word counter and backing-bus driving around a flop-based line array.
module dcache
  import dcache_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned SETS       = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rd_enable,
  input  logic            wr_enable,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wr_data,
  input  mem_access_t     wr_access_type,
  output logic            miss,
  output logic [XLEN-1:0] rd_data,
  dcache_if.master        mem
);

  localparam int unsigned WordW = $clog2(LINE_WORDS);
  localparam int unsigned IdxW  = $clog2(SETS);
  localparam int unsigned TagW  = XLEN - 2 - WordW - IdxW;
  localparam logic [WordW-1:0] LastWord = WordW'(LINE_WORDS - 1);

  dcache_state_t    state_q, state_d;
  logic [WordW-1:0] counter_q, counter_d;

  logic [WordW-1:0] word_sel;
  logic [IdxW-1:0]  index;
  logic [TagW-1:0]  tag;
  logic             line_valid, hit;
  logic [TagW-1:0]  line_tag;
  logic [XLEN-1:0]  line_word;
  logic             fill_en, tag_set_en, merge_en;
  logic [3:0]       wstrb;
  logic [XLEN-1:0]  wlanes;

  assign word_sel = addr[2 +: WordW];
  assign index    = addr[2+WordW +: IdxW];
  assign tag      = addr[XLEN-1 -: TagW];
  assign hit      = line_valid && (line_tag == tag);
  assign wstrb    = get_wr_strobe(wr_access_type, addr[1:0]);
  assign wlanes   = get_wr_lanes(wr_access_type, wr_data);

  dcache_array #(
    .WordW (WordW),
    .IdxW  (IdxW),
    .TagW  (TagW)
  ) u_array (
    .clk           (clk),
    .rst_n         (rst_n),
    .index_i       (index),
    .rd_word_i     (word_sel),
    .valid_o       (line_valid),
    .tag_o         (line_tag),
    .rdata_o       (line_word),
    .fill_en_i     (fill_en),
    .fill_word_i   (counter_q),
    .fill_data_i   (mem.mem_resp_data),
    .tag_set_en_i  (tag_set_en),
    .tag_i         (tag),
    .merge_en_i    (merge_en),
    .merge_strb_i  (wstrb),
    .merge_wdata_i (wlanes)
  );

  always_comb begin
    state_d           = state_q;
    counter_d         = counter_q;
    miss              = 1'b0;
    rd_data           = '0;
    mem.mem_req_valid = 1'b0;
    mem.mem_req_we    = 1'b0;
    mem.mem_req_addr  = '0;
    mem.mem_req_wdata = '0;
    mem.mem_req_wstrb = '0;
    fill_en           = 1'b0;
    tag_set_en        = 1'b0;
    merge_en          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (wr_enable) begin
          miss    = 1'b1;
          state_d = StWriteReq;
        end else if (rd_enable) begin
          if (hit) begin
            rd_data = align_load(line_word, get_load_offset(wr_access_type, addr[1:0]));
          end else begin
            miss      = 1'b1;
            counter_d = '0;
            state_d   = StRefillReq;
          end
        end
      end
      StRefillReq: begin
        miss              = 1'b1;
        mem.mem_req_valid = 1'b1;
        mem.mem_req_addr  = {tag, index, counter_q, 2'b00};
        if (mem.mem_req_ready) state_d = StRefillWait;
      end
      StRefillWait: begin
        miss = 1'b1;
        if (mem.mem_resp_valid) begin
          fill_en = 1'b1;
          if (counter_q == LastWord) begin
            tag_set_en = 1'b1;
            state_d    = StIdle;
          end else begin
            counter_d = counter_q + WordW'(1);
            state_d   = StRefillReq;
          end
        end
      end
      StWriteReq: begin
        miss              = 1'b1;
        mem.mem_req_valid = 1'b1;
        mem.mem_req_we    = 1'b1;
        mem.mem_req_addr  = {addr[XLEN-1:2], 2'b00};
        mem.mem_req_wdata = wlanes;
        mem.mem_req_wstrb = wstrb;
        if (mem.mem_req_ready) begin
          merge_en = hit;
          state_d  = StWriteWait;
        end
      end
      StWriteWait: begin
        miss = 1'b1;
        if (mem.mem_resp_valid) state_d = StAck;
      end
      // One stall-free cycle lets the stage retire the store.
      StAck: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      counter_q <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
    end
  end

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: zero-wait memory model driven from the stimulus
// process, immediate-assertion checks against hand-computed values.
module tb_dcache;
  import dcache_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            rd_enable;
  logic            wr_enable;
  logic [31:0]     addr;
  logic [31:0]     wr_data;
  mem_access_t     wr_access_type;
  logic            miss;
  logic [31:0]     rd_data;

  dcache_if mem_bus ();

  dcache #(
    .LINE_WORDS (4),
    .SETS       (64)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rd_enable      (rd_enable),
    .wr_enable      (wr_enable),
    .addr           (addr),
    .wr_data        (wr_data),
    .wr_access_type (wr_access_type),
    .miss           (miss),
    .rd_data        (rd_data),
    .mem            (mem_bus)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_writes = 0;
  logic        spurious = 1'b0;
  logic [31:0] rd_log [$];
  logic [31:0] mem_model [logic [31:0]];

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'h1234_0000;
  endfunction

  task automatic mem_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    w = mem_read(a);
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    mem_model[a] = w;
  endtask

  // Advance one cycle; a request accepted this cycle is answered in the next.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    acc = rst_n && mem_bus.mem_req_valid && mem_bus.mem_req_ready;
    a   = mem_bus.mem_req_addr;
    if (acc && mem_bus.mem_req_we) begin
      mem_write(a, mem_bus.mem_req_wdata, mem_bus.mem_req_wstrb);
      n_writes++;
    end
    if (acc && !mem_bus.mem_req_we) rd_log.push_back(a);
    @(negedge clk);
    mem_bus.mem_resp_valid = (acc && rst_n) || spurious;
    mem_bus.mem_resp_data  = (acc && !mem_bus.mem_req_we) ? mem_read(a) : 32'h0;
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] a, input mem_access_t t);
    addr = a; wr_access_type = t; rd_enable = 1'b1; wr_enable = 1'b0;
    #1;
  endtask

  task automatic store(input logic [31:0] a, input mem_access_t t, input logic [31:0] d);
    addr = a; wr_access_type = t; wr_data = d; wr_enable = 1'b1; rd_enable = 1'b0;
    #1;
  endtask

  task automatic go_idle();
    rd_enable = 1'b0; wr_enable = 1'b0;
    tick();
  endtask

  // Counts cycles with miss high, starting from the current one; budget-bounded.
  task automatic count_miss(inout int c);
    while (miss && c < 200) begin
      tick();
      c++;
    end
  endtask

  task automatic check_reads(input string tag, input logic [31:0] base);
    check({tag, "_nreads"}, rd_log.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_raddr"}, (i < rd_log.size()) ? rd_log[i] : 32'hFFFF_FFFF,
            base + 32'(4 * i));
    end
  endtask

  initial begin
    int          c;
    int          nw;
    logic [31:0] exp_b [4];
    logic [31:0] held;

    mem_model[32'h100] = 32'hDEAD_BEEF;
    mem_model[32'h200] = 32'h80FF_7F01;
    rst_n = 1'b0; rd_enable = 1'b0; wr_enable = 1'b0;
    addr = '0; wr_data = '0; wr_access_type = WORD;
    mem_bus.mem_req_ready  = 1'b1;
    mem_bus.mem_resp_valid = 1'b0;
    mem_bus.mem_resp_data  = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    check1("rst_miss", miss, 1'b0);
    check("rst_rd_data", rd_data, 32'h0);
    check1("rst_req_valid", mem_bus.mem_req_valid, 1'b0);
    check1("rst_req_we", mem_bus.mem_req_we, 1'b0);
    check("rst_req_addr", mem_bus.mem_req_addr, 32'h0);
    check("rst_req_wdata", mem_bus.mem_req_wdata, 32'h0);
    check("rst_req_wstrb", {28'h0, mem_bus.mem_req_wstrb}, 32'h0);

    // Cold load miss then hit.
    rd_log.delete();
    load(32'h100, WORD);
    check1("l1_miss_first", miss, 1'b1);
    c = 0; count_miss(c);
    check("l1_miss_cycles", c, 32'd9);
    check_reads("l1", 32'h100);
    check("l1_data", rd_data, 32'hDEAD_BEEF);
    go_idle();
    load(32'h100, WORD);
    check1("l1_rehit_miss", miss, 1'b0);
    check("l1_rehit_data", rd_data, 32'hDEAD_BEEF);
    go_idle();

    // Byte/half alignment on a cached line.
    load(32'h200, WORD);
    c = 0; count_miss(c);
    check("l2_miss_cycles", c, 32'd9);
    exp_b[0] = 32'h80FF_7F01; exp_b[1] = 32'h0080_FF7F;
    exp_b[2] = 32'h0000_80FF; exp_b[3] = 32'h0000_0080;
    for (int off = 0; off < 4; off++) begin
      load(32'h200 + 32'(off), BYTE);
      check1("byte_miss", miss, 1'b0);
      check("byte_data", rd_data, exp_b[off]);
      tick();
    end
    load(32'h203, HALF_WORD);
    check("half_ignore_a0", rd_data, 32'h0000_80FF);
    go_idle();

    // Store half to a cached line.
    nw = rd_log.size();
    store(32'h102, HALF_WORD, 32'h0000_ABCD);
    check1("sh_miss_first", miss, 1'b1);
    tick();
    c = 1;
    check1("sh_req_valid", mem_bus.mem_req_valid, 1'b1);
    check1("sh_req_we", mem_bus.mem_req_we, 1'b1);
    check("sh_req_addr", mem_bus.mem_req_addr, 32'h100);
    check("sh_req_wstrb", {28'h0, mem_bus.mem_req_wstrb}, 32'hC);
    check("sh_req_wdata", mem_bus.mem_req_wdata, 32'hABCD_ABCD);
    count_miss(c);
    check("sh_miss_cycles", c, 32'd3);
    go_idle();
    load(32'h100, WORD);
    check1("sh_load_miss", miss, 1'b0);
    check("sh_load_data", rd_data, 32'hABCD_BEEF);
    check("sh_no_refill", rd_log.size(), nw);
    go_idle();

    // Store byte to an uncached line: write only, no allocate.
    rd_log.delete();
    nw = n_writes;
    store(32'h2003, BYTE, 32'h0000_005A);
    tick();
    c = 1;
    check("sb_req_addr", mem_bus.mem_req_addr, 32'h2000);
    check("sb_req_wstrb", {28'h0, mem_bus.mem_req_wstrb}, 32'h8);
    check("sb_req_wdata", mem_bus.mem_req_wdata, 32'h5A5A_5A5A);
    count_miss(c);
    check("sb_miss_cycles", c, 32'd3);
    go_idle();
    check("sb_one_write", n_writes - nw, 32'd1);
    check("sb_no_refill", rd_log.size(), 32'd0);
    load(32'h2000, WORD);
    check1("sb_load_miss", miss, 1'b1);
    c = 0; count_miss(c);
    check("sb_load_cycles", c, 32'd9);
    check_reads("sb", 32'h2000);
    check("sb_load_data", rd_data, 32'h5A34_2000);
    go_idle();

    // Bus back-pressure during REFILL_REQ.
    rd_log.delete();
    mem_bus.mem_req_ready = 1'b0;
    load(32'h300, WORD);
    c = 0;
    tick(); c++;
    held = mem_bus.mem_req_addr;
    check("bp_req_addr", held, 32'h300);
    for (int i = 0; i < 2; i++) begin
      tick(); c++;
      check1("bp_hold_valid", mem_bus.mem_req_valid, 1'b1);
      check1("bp_hold_we", mem_bus.mem_req_we, 1'b0);
      check("bp_hold_addr", mem_bus.mem_req_addr, 32'h300);
    end
    tick(); c++;
    mem_bus.mem_req_ready = 1'b1;
    #1;
    count_miss(c);
    check("bp_miss_cycles", c, 32'd12);
    check("bp_data", rd_data, 32'h1234_0300);
    go_idle();

    // Spurious response while idle.
    spurious = 1'b1;
    tick();
    spurious = 1'b0;
    tick();
    check1("sp_miss", miss, 1'b0);
    check1("sp_req_valid", mem_bus.mem_req_valid, 1'b0);
    load(32'h300, WORD);
    check1("sp_hit_miss", miss, 1'b0);
    check("sp_hit_data", rd_data, 32'h1234_0300);
    go_idle();

    // Reset during the second refill word.
    rd_log.delete();
    load(32'h400, WORD);
    tick(); tick(); tick(); tick();
    check("rr_reads_before", rd_log.size(), 32'd2);
    rst_n = 1'b0;
    rd_enable = 1'b0;
    tick();
    check1("rr_req_dropped", mem_bus.mem_req_valid, 1'b0);
    check1("rr_miss", miss, 1'b0);
    rst_n = 1'b1;
    tick();
    rd_log.delete();
    load(32'h400, WORD);
    check1("rr_line_invalid", miss, 1'b1);
    c = 0; count_miss(c);
    check("rr_miss_cycles", c, 32'd9);
    check_reads("rr", 32'h400);
    check("rr_data", rd_data, 32'h1234_0400);
    go_idle();
    load(32'h100, WORD);
    check1("rr_old_line_invalid", miss, 1'b1);
    c = 0; count_miss(c);
    check("rr_old_line_data", rd_data, 32'hABCD_BEEF);
    go_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
